// File: rtl/eep_sequencer.sv
// EEPROM program/read sequencer: serial image shift, clear, program and read strobes.
// Define EEP_SEQ_VERIFY_EN to add a read-back verify pass after each program.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for pgm_req / read_req
// ST_SHIFT   | shifting the latched image out MSB first, ser_en high
// ST_CLEAR   | eep_clrb low
// ST_PROGRAM | eep_cycleb low for the program pulse
// ST_VERIFY  | eep_cycleb low for a read-back, then one compare cycle
// ST_READ    | eep_cycleb low for a read
// ST_LOAD    | eep_loadb low for one cycle
// ST_DONE    | done pulse, back to idle
module eep_sequencer #(
   parameter int unsigned CACHE_WIDTH = 64,
   parameter int unsigned CLR_CYCLES  = 100,
   parameter int unsigned PGM_CYCLES  = 100,
   parameter int unsigned READ_CYCLES = 4
) (
   input  logic                   sys_clk,
   input  logic                   por,
   input  logic                   pgm_req,
   input  logic                   read_req,
   input  logic [CACHE_WIDTH-1:0] cache_in,
   input  logic [CACHE_WIDTH-1:0] eeprom_cache,
   output logic                   ser_data,
   output logic                   ser_en,
   output logic                   eep_clrb,
   output logic                   eep_cycleb,
   output logic                   eep_loadb,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   verify_fail
);

   function automatic logic [15:0] dur(input int unsigned cycles);
      if (cycles == 0)
         dur = 16'd1;
      else if (cycles > 65535)
         dur = 16'hffff;
      else
         dur = cycles[15:0];
   endfunction

   localparam logic [15:0] SHIFT_LEN = dur(CACHE_WIDTH);
   localparam logic [15:0] CLR_LEN   = dur(CLR_CYCLES);
   localparam logic [15:0] PGM_LEN   = dur(PGM_CYCLES);
   localparam logic [15:0] RD_LEN    = dur(READ_CYCLES);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SHIFT, ST_CLEAR, ST_PROGRAM, ST_VERIFY, ST_READ, ST_LOAD, ST_DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [15:0]            cnt, cnt_nxt;
   logic [CACHE_WIDTH-1:0] shreg;
   logic                   accept_pgm;
   logic                   cycle_low_nxt;
`ifdef EEP_SEQ_VERIFY_EN
   logic                   cmp_now;
`endif

   // cnt counts down to zero; zero is the terminal count of every timed state
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      accept_pgm    = 1'b0;
`ifdef EEP_SEQ_VERIFY_EN
      cmp_now       = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (read_req) begin
               state_nxt = ST_READ;
               cnt_nxt   = RD_LEN - 16'd1;
            end else if (pgm_req) begin
               state_nxt  = ST_SHIFT;
               cnt_nxt    = SHIFT_LEN - 16'd1;
               accept_pgm = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cnt == 16'd0) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = CLR_LEN - 16'd1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         ST_CLEAR: begin
            if (cnt == 16'd0) begin
               state_nxt = ST_PROGRAM;
               cnt_nxt   = PGM_LEN - 16'd1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         ST_PROGRAM: begin
            if (cnt == 16'd0) begin
`ifdef EEP_SEQ_VERIFY_EN
               state_nxt = ST_VERIFY;
               cnt_nxt   = RD_LEN;
`else
               state_nxt = ST_DONE;
               cnt_nxt   = 16'd0;
`endif
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
`ifdef EEP_SEQ_VERIFY_EN
         // one extra count: the final cycle at zero is the compare cycle
         ST_VERIFY: begin
            if (cnt == 16'd0) begin
               state_nxt = ST_DONE;
               cmp_now   = 1'b1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
`endif
         ST_READ: begin
            if (cnt == 16'd0) begin
               state_nxt = ST_LOAD;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         ST_LOAD: begin
            state_nxt = ST_DONE;
            cnt_nxt   = 16'd0;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 16'd0;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 16'd0;
         end
      endcase

      cycle_low_nxt = (state_nxt == ST_PROGRAM) || (state_nxt == ST_READ);
`ifdef EEP_SEQ_VERIFY_EN
      if ((state_nxt == ST_VERIFY) && (cnt_nxt != 16'd0))
         cycle_low_nxt = 1'b1;
`endif
   end

   // outputs are registered from the next state so strobes come straight off flops
   always_ff @(posedge sys_clk or posedge por) begin
      if (por) begin
         state      <= ST_IDLE;
         cnt        <= 16'd0;
         shreg      <= '0;
         ser_en     <= 1'b0;
         eep_clrb   <= 1'b1;
         eep_cycleb <= 1'b1;
         eep_loadb  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         if (accept_pgm)
            shreg <= cache_in;
         else if (state == ST_SHIFT)
            shreg <= (shreg << 1) | (shreg >> (CACHE_WIDTH - 1));
         ser_en     <= (state_nxt == ST_SHIFT);
         eep_clrb   <= (state_nxt != ST_CLEAR);
         eep_cycleb <= !cycle_low_nxt;
         eep_loadb  <= (state_nxt != ST_LOAD);
         busy       <= (state_nxt != ST_IDLE);
         done       <= (state_nxt == ST_DONE);
         err        <= (state != ST_IDLE) && (pgm_req || read_req);
      end
   end

   // shreg rotates, so after the full shift it holds the original image again
   assign ser_data = ser_en & shreg[CACHE_WIDTH-1];

`ifdef EEP_SEQ_VERIFY_EN
   always_ff @(posedge sys_clk or posedge por) begin
      if (por)
         verify_fail <= 1'b0;
      else if (accept_pgm)
         verify_fail <= 1'b0;
      else if (cmp_now && (eeprom_cache != shreg))
         verify_fail <= 1'b1;
   end
`else
   logic unused_eeprom_cache;
   assign unused_eeprom_cache = ^eeprom_cache;
   assign verify_fail = 1'b0;
`endif

endmodule

// File: doc/eep_sequencer.md
EEP_SEQUENCER -- requirements
Module: eep_sequencer

Interface
REQ-001 Parameter CACHE_WIDTH, default 64: width of the EEPROM data image.
REQ-002 Parameter CLR_CYCLES, default 100: number of cycles eep_clrb is held low.
REQ-003 Parameter PGM_CYCLES, default 100: number of cycles eep_cycleb is held low for a program.
REQ-004 Parameter READ_CYCLES, default 4: number of cycles eep_cycleb is held low for a read.
REQ-005 Port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port por, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port pgm_req, input, 1 bit: program request, sampled only in IDLE.
REQ-008 Port read_req, input, 1 bit: read request, sampled only in IDLE.
REQ-009 Port cache_in, input, CACHE_WIDTH bits: image to program, latched on program accept.
REQ-010 Port eeprom_cache, input, CACHE_WIDTH bits: EEPROM read-back image.
REQ-011 Port ser_data, output, 1 bit: serial data to the EEPROM shift chain, MSB first.
REQ-012 Port ser_en, output, 1 bit: high while ser_data is valid.
REQ-013 Port eep_clrb, output, 1 bit: active-low EEPROM clear strobe.
REQ-014 Port eep_cycleb, output, 1 bit: active-low EEPROM program/read cycle strobe.
REQ-015 Port eep_loadb, output, 1 bit: active-low one-cycle strobe that loads read data into the arbiter cache.
REQ-016 Port busy, output, 1 bit: high in every state other than IDLE.
REQ-017 Port done, output, 1 bit: one-cycle pulse on completion of an operation.
REQ-018 Port err, output, 1 bit: one-cycle pulse when a request arrives while busy.
REQ-019 Port verify_fail, output, 1 bit: sticky program-verify mismatch flag.

Function
REQ-020 The FSM SHALL have the states IDLE, SHIFT, CLEAR, PROGRAM, VERIFY, READ, LOAD and DONE.
REQ-021 From IDLE, a sampled read_req SHALL go to READ; otherwise a sampled pgm_req SHALL go to SHIFT. If both are high, read wins and the pgm_req is dropped without setting err.
REQ-022 On program accept, the block SHALL latch cache_in into a shift register.
REQ-023 SHIFT SHALL last exactly CACHE_WIDTH cycles with ser_en=1, shifting one bit per cycle, MSB first, then go to CLEAR.
REQ-024 CLEAR SHALL hold eep_clrb=0 for exactly CLR_CYCLES cycles, then go to PROGRAM.
REQ-025 PROGRAM SHALL hold eep_cycleb=0 for exactly PGM_CYCLES cycles, then go to VERIFY if EEP_SEQ_VERIFY_EN is defined, else to DONE.
REQ-026 READ SHALL hold eep_cycleb=0 for exactly READ_CYCLES cycles, then go to LOAD.
REQ-027 LOAD SHALL hold eep_loadb=0 for one cycle, then go to DONE.
REQ-028 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-029 Total busy time SHALL be CACHE_WIDTH+CLR_CYCLES+PGM_CYCLES+1 cycles for a program without verify, and READ_CYCLES+2 cycles for a read.
REQ-030 The duration counter SHALL be 16 bits, SHALL reload on each state entry and SHALL never wrap. A parameter value of 0 SHALL be treated as 1.
REQ-031 pgm_req or read_req high in any non-IDLE state SHALL be ignored and SHALL pulse err on the next cycle; the operation in progress SHALL be unaffected.
REQ-032 The strobes SHALL be registered and glitch-free; at most one of eep_clrb, eep_cycleb and eep_loadb SHALL be low at any time.

Reset
REQ-033 por=1 SHALL immediately force IDLE and set eep_clrb=eep_cycleb=eep_loadb=1, ser_data=ser_en=busy=done=err=0, verify_fail=0, and clear the counter and shift register, including mid-operation.
REQ-034 After por is released, the first request SHALL be sampled on the first rising edge of sys_clk.

Configuration
REQ-035 With EEP_SEQ_VERIFY_EN defined, the block SHALL run VERIFY after PROGRAM.
- VERIFY holds eep_cycleb=0 for READ_CYCLES cycles, then spends one cycle comparing eeprom_cache to the latched image.
- A mismatch sets verify_fail (cleared only by the next program accept or by por).
- VERIFY then goes to DONE.
REQ-036 Without EEP_SEQ_VERIFY_EN, the VERIFY logic SHALL be absent and verify_fail SHALL be tied 0.

Verification (bench parameters: CACHE_WIDTH=64, CLR_CYCLES=4, PGM_CYCLES=8, READ_CYCLES=2)
REQ-037 Program: pgm_req pulse with cache_in=64'hA5A5_0000_FFFF_1234 -> ser_data shows that value MSB first over 64 cycles with ser_en=1, then eep_clrb low for 4 cycles, then eep_cycleb low for 8 cycles, then done pulses; busy lasts 77 cycles.
REQ-038 Read: read_req pulse -> eep_cycleb low for 2 cycles, eep_loadb low for 1 cycle, done on the 4th cycle, busy lasts 4 cycles.
REQ-039 Simultaneous request: pgm_req=read_req=1 in IDLE -> read sequence only, err=0.
REQ-040 Request while busy: read_req during SHIFT cycle 10 -> err pulses once and the program completes unchanged.
REQ-041 Reset mid-operation: por asserted during PROGRAM cycle 3 -> all outputs at reset values before the next edge; a new pgm_req after release runs a full sequence.
REQ-042 With EEP_SEQ_VERIFY_EN: eeprom_cache differing from cache_in in bit 0 -> verify_fail=1 after the compare cycle, done pulses; a following matching program clears verify_fail.
